// File: rtl/iir_pkg.sv
// Shared types, constants and fixed-point helpers for the TDM biquad.
// Helpers work on a 64-bit signed carrier, so every width they are given must stay below 64.
package iir_pkg;

    localparam int unsigned DEF_COEF_FRAC = 14;
    localparam int          COEF_ONE      = 1 << DEF_COEF_FRAC;
    localparam int unsigned WIDE_W        = 64;

    typedef logic signed [WIDE_W-1:0] wide_t;

    typedef enum logic [2:0] {
        StIdle,
        StC0,
        StC1,
        StC2,
        StC3,
        StC4,
        StOut
    } state_e;

    function automatic int unsigned ch_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic wide_t max_of(input int unsigned w);
        return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    endfunction

    function automatic wide_t min_of(input int unsigned w);
        return -(wide_t'(1) <<< (w - 1));
    endfunction

    // Round half toward +inf, then drop the fraction bits.
    function automatic wide_t rnd_shift(input wide_t v, input int unsigned frac);
        wide_t half;
        half = (frac == 0) ? wide_t'(0) : (wide_t'(1) <<< (frac - 1));
        return (v + half) >>> frac;
    endfunction

    function automatic wide_t sat(input wide_t v, input int unsigned w);
        if (v > max_of(w)) return max_of(w);
        if (v < min_of(w)) return min_of(w);
        return v;
    endfunction

    function automatic logic clipped(input wide_t v, input int unsigned w);
        return (v > max_of(w)) || (v < min_of(w));
    endfunction

endpackage

// File: rtl/iir_biquad_tdm_if.sv
// Sample-in / sample-out stream bundle of the TDM biquad.
interface iir_biquad_tdm_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CH_W   = 2
);
    logic                     in_valid;
    logic                     in_ready;
    logic [CH_W-1:0]          in_ch;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [CH_W-1:0]          out_ch;
    logic signed [DATA_W-1:0] out_data;
    logic                     ovf;
    logic                     ch_err;

    modport master (
        output in_valid, in_ch, in_data, out_ready,
        input  in_ready, out_valid, out_ch, out_data, ovf, ch_err
    );

    modport slave (
        input  in_valid, in_ch, in_data, out_ready,
        output in_ready, out_valid, out_ch, out_data, ovf, ch_err
    );
endinterface

// File: rtl/iir_mac.sv
// Single shared multiplier: acc <= sat(addend +/- coef*data), with the pre-register sum exposed.
module iir_mac
    import iir_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned COEF_W = 16,
    parameter int unsigned ACC_W  = 40
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     sub,
    input  logic signed [COEF_W-1:0] coef,
    input  logic signed [DATA_W-1:0] data,
    input  logic signed [ACC_W-1:0]  addend,
    output logic signed [ACC_W-1:0]  acc_next,
    output logic signed [ACC_W-1:0]  acc
);

    wide_t prod;
    wide_t sum;

    always_comb begin
        prod     = wide_t'(coef) * wide_t'(data);
        sum      = sub ? (wide_t'(addend) - prod) : (wide_t'(addend) + prod);
        acc_next = ACC_W'(sat(sum, ACC_W));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/iir_biquad_tdm.sv
// Time-multiplexed transposed-DF-II biquad: one multiply per state, per-channel s1/s2 in arrays.
module iir_biquad_tdm
    import iir_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned COEF_W    = 16,
    parameter int unsigned COEF_FRAC = DEF_COEF_FRAC,
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned ACC_W     = 40
) (
    input logic                     clk,
    input logic                     rst_n,
    input logic                     clr,
    input logic signed [COEF_W-1:0] b0,
    input logic signed [COEF_W-1:0] b1,
    input logic signed [COEF_W-1:0] b2,
    input logic signed [COEF_W-1:0] a1,
    input logic signed [COEF_W-1:0] a2,
    iir_biquad_tdm_if.slave         bus
);

    localparam int unsigned CH_W = ch_w(NUM_CH);

    state_e state_q, state_d;

    logic signed [COEF_W-1:0] b0_q, b1_q, b2_q, a1_q, a2_q;
    logic signed [DATA_W-1:0] x_q, y_q, y_d;
    logic [CH_W-1:0]          ch_q;
    logic                     ovf_q, ovf_d, ch_err_q;
    logic signed [ACC_W-1:0]  s1_q [NUM_CH];
    logic signed [ACC_W-1:0]  s2_q [NUM_CH];
    logic signed [ACC_W-1:0]  s1n_q;

    logic                     take, ch_ok, busy;
    logic                     mac_en, mac_sub;
    logic signed [COEF_W-1:0] mac_coef;
    logic signed [DATA_W-1:0] mac_data;
    logic signed [ACC_W-1:0]  mac_addend, acc_next, acc;
    wide_t                    y_rnd;

    assign take  = (state_q == StIdle) && bus.in_valid;
    assign ch_ok = int'(bus.in_ch) < int'(NUM_CH);
    assign busy  = (state_q == StC0) || (state_q == StC1) || (state_q == StC2) ||
                   (state_q == StC3) || (state_q == StC4);

    always_comb begin
        state_d    = state_q;
        mac_en     = 1'b0;
        mac_sub    = 1'b0;
        mac_coef   = b0_q;
        mac_data   = x_q;
        mac_addend = '0;
        unique case (state_q)
            StIdle: if (take && ch_ok) state_d = StC0;
            StC0: begin
                mac_en     = 1'b1;
                mac_addend = s1_q[ch_q];
                state_d    = StC1;
            end
            StC1: begin
                mac_en     = 1'b1;
                mac_coef   = b1_q;
                mac_addend = s2_q[ch_q];
                state_d    = StC2;
            end
            StC2: begin
                mac_en     = 1'b1;
                mac_sub    = 1'b1;
                mac_coef   = a1_q;
                mac_data   = y_q;
                mac_addend = acc;
                state_d    = StC3;
            end
            StC3: begin
                mac_en   = 1'b1;
                mac_coef = b2_q;
                state_d  = StC4;
            end
            StC4: begin
                mac_en     = 1'b1;
                mac_sub    = 1'b1;
                mac_coef   = a2_q;
                mac_data   = y_q;
                mac_addend = acc;
                state_d    = StOut;
            end
            StOut:   if (bus.out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (clr && busy) state_d = StIdle;
    end

    // acc holds b0*x + s1 while in C1; y is taken from it at the C1 exit edge.
    always_comb begin
        y_rnd = rnd_shift(wide_t'(acc), COEF_FRAC);
        y_d   = DATA_W'(sat(y_rnd, DATA_W));
        ovf_d = clipped(y_rnd, DATA_W);
    end

    iir_mac #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (mac_en),
        .sub      (mac_sub),
        .coef     (mac_coef),
        .data     (mac_data),
        .addend   (mac_addend),
        .acc_next (acc_next),
        .acc      (acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b0_q     <= '0;
            b1_q     <= '0;
            b2_q     <= '0;
            a1_q     <= '0;
            a2_q     <= '0;
            x_q      <= '0;
            ch_q     <= '0;
            y_q      <= '0;
            ovf_q    <= 1'b0;
            ch_err_q <= 1'b0;
            s1n_q    <= '0;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                s1_q[i] <= '0;
                s2_q[i] <= '0;
            end
        end else begin
            ch_err_q <= take && !ch_ok;
            if (take && ch_ok) begin
                x_q  <= bus.in_data;
                ch_q <= bus.in_ch;
                b0_q <= b0;
                b1_q <= b1;
                b2_q <= b2;
                a1_q <= a1;
                a2_q <= a2;
            end
            if (state_q == StC1) begin
                y_q   <= y_d;
                ovf_q <= ovf_d;
            end
            if (state_q == StC3) s1n_q <= acc;
            if (clr) begin
                for (int i = 0; i < int'(NUM_CH); i++) begin
                    s1_q[i] <= '0;
                    s2_q[i] <= '0;
                end
            end else if (state_q == StC4) begin
                s1_q[ch_q] <= s1n_q;
                s2_q[ch_q] <= acc_next;
            end
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StOut);
    assign bus.out_ch    = ch_q;
    assign bus.out_data  = y_q;
    assign bus.ovf       = ovf_q;
    assign bus.ch_err    = ch_err_q;

endmodule
